// File: rtl/rv_pkg.sv
// Shared pipeline definitions: memory arbiter state encoding and
// default address/data widths.
package rv_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch/data priority pick with a starvation counter that forces a
// fetch grant after STARVE_MAX data grants made while a fetch waits.
module mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic fetch_i,
    input  logic data_i,
    input  logic if_req_i,
    output logic gnt_if_o,
    output logic gnt_dm_o
);

    localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       starve;
    logic       dm_win;

    always_comb begin
        starve   = fetch_i && (cnt_q == MAX_C);
        dm_win   = data_i && !starve;
        gnt_dm_o = en_i && dm_win;
        gnt_if_o = en_i && fetch_i && !dm_win;
        cnt_d    = cnt_q;
        if (gnt_if_o) begin
            cnt_d = '0;
        end else if (gnt_dm_o) begin
            if (!if_req_i) begin
                cnt_d = '0;
            end else if (cnt_q < MAX_C) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data
// stage; memory-side request is held frozen until mem_ready.
module mem_port_arbiter
    import rv_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e        state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic busy_if;
    logic busy_dm;
    logic arb_en;
    logic fetch_c;
    logic data_c;
    logic gnt_if;
    logic gnt_dm;

    assign busy_if = (state_q == ARB_BUSY_IF);
    assign busy_dm = (state_q == ARB_BUSY_DM);
    assign arb_en  = (state_q == ARB_IDLE) || mem_ready;

    // The requester finishing this cycle must not be re-granted.
    assign fetch_c = if_req && !(busy_if && mem_ready);
    assign data_c  = dm_req && !(busy_dm && mem_ready);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (arb_en),
        .fetch_i  (fetch_c),
        .data_i   (data_c),
        .if_req_i (if_req),
        .gnt_if_o (gnt_if),
        .gnt_dm_o (gnt_dm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (arb_en) begin
            if (gnt_dm) begin
                state_q <= ARB_BUSY_DM;
                we_q    <= dm_we;
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
            end else if (gnt_if) begin
                state_q <= ARB_BUSY_IF;
                we_q    <= 1'b0;
                addr_q  <= if_addr;
            end else begin
                state_q <= ARB_IDLE;
            end
        end
    end

    assign mem_req   = (state_q != ARB_IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_valid  = busy_if && mem_ready;
    assign dm_valid  = busy_dm && mem_ready;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

    assign stall_if  = if_req && !if_valid;
    assign stall_mem = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state memory model.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;

    logic        force_rdy;
    logic [3:0]  waits;
    logic [3:0]  wcnt_q;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    // Memory: completes after 'waits' stalled cycles of mem_req.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt_q <= '0;
        else if (mem_req && !mem_ready) wcnt_q <= wcnt_q + 4'd1;
        else wcnt_q <= '0;
    end

    assign mem_ready = force_rdy || (mem_req && (wcnt_q == waits));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    int lat;

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h40;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = 32'h0000_0013;
        force_rdy = 1'b1;
        waits     = 4'd0;

        // reset state
        smp();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall_if", 32'(stall_if), 32'd1);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        drv();
        rst_n = 1'b1;
        smp();
        chk("rel_mem_req", 32'(mem_req), 32'd0);
        drv();
        smp();
        chk("fetch_mem_req", 32'(mem_req), 32'd1);
        chk("fetch_addr", mem_addr, 32'h40);
        chk("fetch_valid", 32'(if_valid), 32'd1);
        chk("fetch_rdata", if_rdata, 32'h0000_0013);
        chk("fetch_stall", 32'(stall_if), 32'd0);
        drv();
        if_req = 1'b0;
        force_rdy = 1'b0;
        smp();
        chk("fetch_idle", 32'(mem_req), 32'd0);
        chk("fetch_pulse", 32'(if_valid), 32'd0);

        // single load, 2 wait cycles, with address churn
        waits = 4'd2;
        mem_rdata = 32'hDEAD_BEEF;
        drv();
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h100;
        smp();
        chk("ld_stall0", 32'(stall_mem), 32'd1);
        chk("ld_req0", 32'(mem_req), 32'd0);
        drv();
        smp();
        chk("ld_addr1", mem_addr, 32'h100);
        chk("ld_we1", 32'(mem_we), 32'd0);
        chk("ld_valid1", 32'(dm_valid), 32'd0);
        chk("ld_stall1", 32'(stall_mem), 32'd1);
        drv();
        dm_addr = 32'h300;
        smp();
        chk("ld_addr2", mem_addr, 32'h100);
        chk("ld_valid2", 32'(dm_valid), 32'd0);
        drv();
        smp();
        chk("ld_churn_addr", mem_addr, 32'h100);
        chk("ld_valid3", 32'(dm_valid), 32'd1);
        chk("ld_rdata", dm_rdata, 32'hDEAD_BEEF);
        chk("ld_stall3", 32'(stall_mem), 32'd0);
        drv();
        dm_req = 1'b0;
        smp();
        chk("ld_idle", 32'(mem_req), 32'd0);
        chk("ld_pulse", 32'(dm_valid), 32'd0);

        // conflict: store wins, fetch follows with no idle cycle
        waits = 4'd0;
        mem_rdata = 32'h1234_5678;
        drv();
        if_req = 1'b1;
        if_addr = 32'h44;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h200;
        dm_wdata = 32'hCAFE_F00D;
        smp();
        drv();
        smp();
        chk("cf_st_addr", mem_addr, 32'h200);
        chk("cf_st_we", 32'(mem_we), 32'd1);
        chk("cf_st_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("cf_st_valid", 32'(dm_valid), 32'd1);
        chk("cf_if_wait", 32'(if_valid), 32'd0);
        drv();
        dm_req = 1'b0;
        dm_we = 1'b0;
        smp();
        chk("cf_b2b_req", 32'(mem_req), 32'd1);
        chk("cf_if_addr", mem_addr, 32'h44);
        chk("cf_if_we", 32'(mem_we), 32'd0);
        chk("cf_if_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("cf_if_valid", 32'(if_valid), 32'd1);
        chk("cf_if_rdata", if_rdata, 32'h1234_5678);
        drv();
        if_req = 1'b0;
        smp();
        chk("cf_idle", 32'(mem_req), 32'd0);

        // starvation: 4 data grants with a fetch pending, then fetch
        for (int i = 0; i < 4; i++) begin
            drv();
            if_req = 1'b1;
            if_addr = 32'h80;
            dm_req = 1'b1;
            dm_addr = 32'h400 + 32'(i * 4);
            smp();
            drv();
            if_req = 1'b0;
            smp();
            chk($sformatf("sv_dm_addr%0d", i), mem_addr, 32'h400 + 32'(i * 4));
            chk($sformatf("sv_dm_valid%0d", i), 32'(dm_valid), 32'd1);
            drv();
            dm_req = 1'b0;
            smp();
        end
        drv();
        if_req = 1'b1;
        dm_req = 1'b1;
        dm_addr = 32'h500;
        smp();
        drv();
        smp();
        chk("sv_force_addr", mem_addr, 32'h80);
        chk("sv_force_ifv", 32'(if_valid), 32'd1);
        chk("sv_force_dmv", 32'(dm_valid), 32'd0);
        drv();
        if_req = 1'b0;
        smp();
        chk("sv_resume_addr", mem_addr, 32'h500);
        chk("sv_resume_v", 32'(dm_valid), 32'd1);
        drv();
        dm_req = 1'b0;
        smp();
        drv();
        if_req = 1'b1;
        dm_req = 1'b1;
        dm_addr = 32'h504;
        smp();
        drv();
        smp();
        chk("sv_cnt_clr", mem_addr, 32'h504);
        chk("sv_cnt_clr_v", 32'(dm_valid), 32'd1);
        drv();
        dm_req = 1'b0;
        smp();
        drv();
        if_req = 1'b0;
        smp();

        // reset mid-access abandons the load
        waits = 4'd3;
        mem_rdata = 32'h0BAD_F00D;
        drv();
        dm_req = 1'b1;
        dm_addr = 32'h600;
        smp();
        drv();
        smp();
        chk("mr_busy", 32'(mem_req), 32'd1);
        drv();
        rst_n = 1'b0;
        smp();
        chk("mr_req", 32'(mem_req), 32'd0);
        chk("mr_addr", mem_addr, 32'h0);
        chk("mr_valid", 32'(dm_valid), 32'd0);
        drv();
        smp();
        chk("mr_valid_b", 32'(dm_valid), 32'd0);
        drv();
        rst_n = 1'b1;
        lat = 0;
        smp();
        while (!dm_valid && lat < 12) begin
            drv();
            lat++;
            smp();
        end
        chk("mr_latency", 32'(lat), 32'd4);
        chk("mr_addr_after", mem_addr, 32'h600);
        chk("mr_rdata", dm_rdata, 32'h0BAD_F00D);
        drv();
        dm_req = 1'b0;
        smp();
        chk("mr_idle", 32'(mem_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
